// File: rtl/vic_arb_pkg.sv
// vic_arb_pkg: shared types for the video/CPU RAM arbiter.
// Holds the arbiter FSM states, the slot-owner tag and the default starve limit.
package vic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ACK
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        VID,
        CPU
    } slot_owner_t;

    localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/vic_arb_stats.sv
// vic_arb_stats: saturating arbitration counters (built only with ARB_STATS_EN).
// Ports: clk/reset, stat_clr (sync clear), win/stall/steal event strobes, three count outputs.
module vic_arb_stats
    import vic_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stat_clr,
    input  logic        cpu_win,
    input  logic        stall,
    input  logic        steal,
    output logic [15:0] stat_cpu_grants,
    output logic [15:0] stat_stall,
    output logic [7:0]  stat_steals
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_cpu_grants <= '0;
            stat_stall      <= '0;
            stat_steals     <= '0;
        end else if (stat_clr) begin
            stat_cpu_grants <= '0;
            stat_stall      <= '0;
            stat_steals     <= '0;
        end else begin
            if (cpu_win && stat_cpu_grants != '1)
                stat_cpu_grants <= stat_cpu_grants + 16'd1;
            if (stall && stat_stall != '1)
                stat_stall <= stat_stall + 16'd1;
            if (steal && stat_steals != '1)
                stat_steals <= stat_steals + 8'd1;
        end
    end

endmodule

// File: rtl/vic_mem_arbiter.sv
// vic_mem_arbiter: shares one 1-cycle-latency byte RAM between video fetch (priority) and CPU.
// Ports: vid_* (read-only video slot), cpu_* (level req / ack pulse), mem_* (RAM side).
// Optional ARB_STATS_EN adds stat_clr and stat_cpu_grants/stat_stall/stat_steals.
module vic_mem_arbiter
    import vic_arb_pkg::*;
#(
    parameter int AW           = 16,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_valid,
    output logic          vid_miss,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
`ifdef ARB_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   stat_cpu_grants,
    output logic [15:0]   stat_stall,
    output logic [7:0]    stat_steals
`endif
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state;
    arb_state_t    state_nx;
    slot_owner_t   owner;
    logic [WW-1:0] wait_cnt;
    logic [AW-1:0] last_addr;
    logic          starved;
    logic          cpu_win;
    logic          steal;

    assign starved  = (wait_cnt == WW'(STARVE_LIMIT));
    assign vid_data = mem_rdata;

    always_comb begin
        owner = NONE;
        if (state == IDLE && cpu_req && (!vid_req || starved))
            owner = CPU;
        else if (vid_req)
            owner = VID;
    end

    assign cpu_win = (owner == CPU);
    assign steal   = cpu_win && vid_req;

    // Idle bus keeps the previous address so the RAM sees no spurious toggling.
    always_comb begin
        mem_addr  = last_addr;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        case (owner)
            CPU: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we && !reset;
                mem_wdata = cpu_wdata;
            end
            VID: mem_addr = vid_addr;
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (cpu_win) state_nx = cpu_we ? ACK : DATA;
            DATA: state_nx = ACK;
            ACK:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            last_addr <= '0;
            vid_valid <= 1'b0;
            vid_miss  <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= 8'h00;
        end else begin
            state     <= state_nx;
            last_addr <= mem_addr;
            vid_valid <= (owner == VID);
            vid_miss  <= steal;
            cpu_ack   <= (state_nx == ACK);
            if (state == DATA)
                cpu_rdata <= mem_rdata;
            // Counter only advances while the CPU is held off by video in IDLE.
            if (cpu_win || !cpu_req)
                wait_cnt <= '0;
            else if (state == IDLE && vid_req && !starved)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    logic stall;
    assign stall = (state == IDLE) && cpu_req && !cpu_win;

    vic_arb_stats u_stats (
        .clk             (clk),
        .reset           (reset),
        .stat_clr        (stat_clr),
        .cpu_win         (cpu_win),
        .stall           (stall),
        .steal           (steal),
        .stat_cpu_grants (stat_cpu_grants),
        .stat_stall      (stat_stall),
        .stat_steals     (stat_steals)
    );
`endif

endmodule

// File: tb/tb_vic_mem_arbiter.sv
// tb_vic_mem_arbiter: directed checks of vic_mem_arbiter against a behavioural RAM.
// Covers reset, CPU read/write latency, starvation steal, idle-slot win and (optionally) stats.
module tb_vic_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        vid_miss;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
`ifdef ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_cpu_grants;
    logic [15:0] stat_stall;
    logic [7:0]  stat_steals;
`endif

    logic [7:0] ram [0:65535];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    vic_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .vid_miss  (vid_miss),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .stat_clr        (stat_clr),
        .stat_cpu_grants (stat_cpu_grants),
        .stat_stall      (stat_stall),
        .stat_steals     (stat_steals)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Continuous video with a pending CPU read of 0x1000 (holds 0xA5).
    task automatic starve_run;
        int miss;
        miss = 0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h1000;
        vid_req  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vid_addr = 16'h1E00 + 16'(i);
            #1;
            chk("starve_vid_slot", {16'h0, mem_addr}, 32'h1E00 + i);
            tick;
            miss += int'(vid_miss);
        end
        vid_addr = 16'h1E08;
        #1;
        chk("starve_cpu_issue", {16'h0, mem_addr}, 32'h1000);
        chk("starve_issue_we", {31'h0, mem_we}, 32'h0);
        tick;
        miss += int'(vid_miss);
        chk("steal_miss", {31'h0, vid_miss}, 32'h1);
        chk("steal_valid", {31'h0, vid_valid}, 32'h0);
        chk("starve_ack_early", {31'h0, cpu_ack}, 32'h0);
        vid_addr = 16'h1E09;
        tick;
        miss += int'(vid_miss);
        chk("starve_ack", {31'h0, cpu_ack}, 32'h1);
        chk("starve_rdata", {24'h0, cpu_rdata}, 32'hA5);
        chk("starve_vid_back", {31'h0, vid_valid}, 32'h1);
        cpu_req  = 1'b0;
        vid_addr = 16'h1E0A;
        tick;
        miss += int'(vid_miss);
        chk("miss_once", miss, 32'h1);
        vid_req = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ram[16'h1000] = 8'hA5;
        reset     = 1'b1;
        vid_req   = 1'b0;
        vid_addr  = 16'h0000;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h3000;
        cpu_wdata = 8'hFF;
`ifdef ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        tick;
        tick;
        chk("rst_no_we", {31'h0, mem_we}, 32'h0);
        chk("rst_ack", {31'h0, cpu_ack}, 32'h0);
        chk("rst_vvalid", {31'h0, vid_valid}, 32'h0);
        chk("rst_vmiss", {31'h0, vid_miss}, 32'h0);
        chk("rst_rdata", {24'h0, cpu_rdata}, 32'h0);
`ifdef ARB_STATS_EN
        chk("rst_st_grants", {16'h0, stat_cpu_grants}, 32'h0);
        chk("rst_st_stall", {16'h0, stat_stall}, 32'h0);
        chk("rst_st_steals", {24'h0, stat_steals}, 32'h0);
`endif
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick;
        reset = 1'b0;
        tick;

        // CPU read, no video
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h1000;
        #1;
        chk("rd_issue_addr", {16'h0, mem_addr}, 32'h1000);
        chk("rd_issue_we", {31'h0, mem_we}, 32'h0);
        tick;
        chk("rd_c1_ack", {31'h0, cpu_ack}, 32'h0);
        tick;
        chk("rd_c2_ack", {31'h0, cpu_ack}, 32'h1);
        chk("rd_c2_data", {24'h0, cpu_rdata}, 32'hA5);
        cpu_req = 1'b0;
        tick;
        chk("rd_ack_pulse", {31'h0, cpu_ack}, 32'h0);

        // CPU write, then video reads it back
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h2000;
        cpu_wdata = 8'h3C;
        #1;
        chk("wr_issue_we", {31'h0, mem_we}, 32'h1);
        chk("wr_issue_data", {24'h0, mem_wdata}, 32'h3C);
        tick;
        chk("wr_we_one_cycle", {31'h0, mem_we}, 32'h0);
        chk("wr_ack", {31'h0, cpu_ack}, 32'h1);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick;
        chk("wr_ack_pulse", {31'h0, cpu_ack}, 32'h0);
        vid_req  = 1'b1;
        vid_addr = 16'h2000;
        #1;
        chk("vrd_addr", {16'h0, mem_addr}, 32'h2000);
        tick;
        chk("vrd_valid", {31'h0, vid_valid}, 32'h1);
        chk("vrd_data", {24'h0, vid_data}, 32'h3C);
        vid_req = 1'b0;
        tick;
        chk("vrd_valid_drop", {31'h0, vid_valid}, 32'h0);

        // Reset while the read is in DATA
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h1000;
        tick;
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk("mid_rst_ack", {31'h0, cpu_ack}, 32'h0);
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk("post_rst_ack", {31'h0, cpu_ack}, 32'h0);
        chk("post_rst_rdata", {24'h0, cpu_rdata}, 32'h0);
        chk("post_rst_vvalid", {31'h0, vid_valid}, 32'h0);
        chk("post_rst_vmiss", {31'h0, vid_miss}, 32'h0);
        tick;
        chk("post_rst_ack2", {31'h0, cpu_ack}, 32'h0);

        // Starvation steal
        starve_run;

        // Alternating video leaves idle slots for the CPU
        vid_req  = 1'b1;
        vid_addr = 16'h1E20;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h2000;
        #1;
        chk("alt_vid_first", {16'h0, mem_addr}, 32'h1E20);
        tick;
        vid_req = 1'b0;
        #1;
        chk("alt_cpu_gap", {16'h0, mem_addr}, 32'h2000);
        tick;
        chk("alt_no_miss1", {31'h0, vid_miss}, 32'h0);
        chk("alt_wait_clr", {31'h0, 1'(dut.wait_cnt != 0)}, 32'h0);
        vid_req  = 1'b1;
        vid_addr = 16'h1E21;
        tick;
        chk("alt_ack", {31'h0, cpu_ack}, 32'h1);
        chk("alt_rdata", {24'h0, cpu_rdata}, 32'h3C);
        chk("alt_no_miss2", {31'h0, vid_miss}, 32'h0);
        cpu_req = 1'b0;
        vid_req = 1'b0;
        tick;

`ifdef ARB_STATS_EN
        stat_clr = 1'b1;
        tick;
        stat_clr = 1'b0;
        starve_run;
        starve_run;
        chk("st_grants", {16'h0, stat_cpu_grants}, 32'd2);
        chk("st_stall", {16'h0, stat_stall}, 32'd16);
        chk("st_steals", {24'h0, stat_steals}, 32'd2);
        stat_clr = 1'b1;
        tick;
        stat_clr = 1'b0;
        chk("st_clr_grants", {16'h0, stat_cpu_grants}, 32'h0);
        chk("st_clr_stall", {16'h0, stat_stall}, 32'h0);
        chk("st_clr_steals", {24'h0, stat_steals}, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
